// File: rtl/dff_response_checker.sv
// dff_response_checker: cycle-accurate reference monitor for a D flip-flop with
// active-low clear/preset. Counts checked samples, mismatches and illegal
// clear+preset samples, and keeps a first-error snapshot.
// Build option: define DFF_CHK_STOP_ON_ERR_EN to halt on the first mismatch.
module dff_response_checker #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              mon_d,
    input  logic              mon_clear,
    input  logic              mon_preset,
    input  logic              mon_q,
    input  logic              mon_q_bar,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  illegal_count,
    output logic [TS_W-1:0]   first_err_ts,
    output logic [2:0]        first_err_info,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {IDLE, PRIME, CHECK, HALT} state_t;

    localparam int W = (CNT_W > TS_W) ? CNT_W : TS_W;
    localparam logic [TS_W-1:0] TS_MAX = '1;

    state_t             state_q, state_d;
    logic               exp_q, exp_d;
    logic               exp_valid_q, exp_valid_d;
    logic               err_flag_q, err_flag_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [2:0]         info_q, info_d;

    logic               illegal, exp_now, pins_ok, checking, mismatch, halt_now;
    logic [W-1:0]       smp_wide;
    logic [TS_W-1:0]    ts_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction

    assign illegal  = !mon_clear && !mon_preset;
    assign exp_now  = !mon_clear ? 1'b0 : !mon_preset ? 1'b1 : exp_q;
    assign checking = enable && state_q == CHECK && exp_valid_q;
    assign mismatch = checking && !illegal && !pins_ok;
    assign smp_wide = W'(smp_cnt_q);
    assign ts_now   = (smp_wide > W'(TS_MAX)) ? TS_MAX : TS_W'(smp_wide);

`ifdef DFF_CHK_STOP_ON_ERR_EN
    assign halt_now = mismatch;
`else
    assign halt_now = 1'b0;
`endif

    // Pin agreement; an X/Z on any pin falls to the else path and reads as a mismatch.
    always_comb begin
        pins_ok = 1'b0;
        if ((mon_q == exp_now) && (mon_q_bar != mon_q)) pins_ok = 1'b1;
    end

    // Next-state for the FSM, reference model, counters and first-error snapshot.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        exp_valid_d = exp_valid_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        ts_d        = ts_q;
        info_d      = info_q;
        if (enable && state_q != HALT) begin
            exp_d       = !mon_clear ? 1'b0 : !mon_preset ? 1'b1 : mon_d;
            exp_valid_d = state_q != IDLE;
            state_d     = state_q == IDLE ? PRIME : state_q == PRIME ? CHECK : halt_now ? HALT : CHECK;
        end
        if (checking) begin
            if (!halt_now) smp_cnt_d = sat_inc(smp_cnt_q);
            if (illegal) ill_cnt_d = sat_inc(ill_cnt_q);
            if (mismatch) begin
                err_cnt_d  = sat_inc(err_cnt_q);
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    ts_d   = ts_now;
                    info_d = {exp_now, mon_q, mon_q_bar};
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            exp_q       <= 1'b0;
            exp_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            ill_cnt_q   <= '0;
            ts_q        <= '0;
            info_q      <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            exp_valid_q <= exp_valid_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
            ts_q        <= ts_d;
            info_q      <= info_d;
        end
    end

    assign err_flag       = err_flag_q;
    assign err_count      = err_cnt_q;
    assign sample_count   = smp_cnt_q;
    assign illegal_count  = ill_cnt_q;
    assign first_err_ts   = ts_q;
    assign first_err_info = info_q;
    assign state          = state_q;
endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
- Synthesizable self-checking monitor for the D flip-flop with active-low clear/preset.
- Sits beside the flip-flop and observes its d, clear, preset, q and q_bar pins.
- Runs a cycle-accurate reference model and counts mismatches.
- Reports sticky error status and a first-error snapshot for bench or on-chip readout.

Parameters:
- CNT_W, 8, width of the error and sample counters (saturating).
- TS_W, 16, width of the first-error timestamp (sample index).

Ports:
- clk  input  1  monitor clock, same clock as the observed flip-flop.
- clear  input  1  asynchronous active-low reset of this checker.
- enable  input  1  1 = sample and check on this edge; 0 = hold all state.
- mon_d  input  1  observed flip-flop d.
- mon_clear  input  1  observed flip-flop clear (active-low).
- mon_preset  input  1  observed flip-flop preset (active-low).
- mon_q  input  1  observed flip-flop q.
- mon_q_bar  input  1  observed flip-flop q_bar.
- err_flag  output  1  sticky; 1 after any mismatch.
- err_count  output  CNT_W  number of mismatching samples.
- sample_count  output  CNT_W  number of checked samples.
- illegal_count  output  CNT_W  samples with mon_clear=0 and mon_preset=0 at the same time.
- first_err_ts  output  TS_W  sample_count value at the first mismatch.
- first_err_info  output  3  {expected_q, mon_q, mon_q_bar} captured at the first mismatch.
- state  output  2  FSM state: 0 IDLE, 1 PRIME, 2 CHECK, 3 HALT.

Behaviour:
- Reset (clear=0, asynchronous):
  - All counters, err_flag, first_err_ts, first_err_info and the internal exp_q/exp_valid go to 0.
  - state goes to IDLE.
- All state updates occur on the rising edge of clk, only when enable=1. enable=0 freezes the FSM, counters and model.
- Expected value at a sample, exp_now, in priority order:
  - mon_clear=0 and mon_preset=0: illegal; exp_now is undefined.
  - mon_clear=0: exp_now=0.
  - mon_preset=0: exp_now=1.
  - Otherwise: exp_now=exp_q, the next-state computed at the previous sample.
- Model update every enabled edge: exp_q <= (!mon_clear)?0 : (!mon_preset)?1 : mon_d.
- FSM:
  - IDLE -> PRIME on the first enabled edge; the model loads, nothing is checked.
  - PRIME -> CHECK on the next enabled edge; exp_valid=1 from here.
  - CHECK stays in CHECK.
  - Any state -> IDLE only via reset.
- Check, in CHECK only:
  - Mismatch when mon_q != exp_now, or when mon_q_bar != ~mon_q.
  - Illegal sample (both pins low): no compare; illegal_count increments. q=q_bar=1 is not flagged.
  - Every checked sample, illegal or not, increments sample_count.
  - On mismatch, err_count increments and err_flag is set.
  - On the first mismatch only, first_err_ts and first_err_info capture the current sample_count (the value before increment) and {exp_now, mon_q, mon_q_bar}.
- All counters saturate at all-ones and never wrap. first_err_ts saturates at all-ones.
- Asserting clear mid-run discards the model. The checker restarts in IDLE and needs two enabled edges before checking resumes.
- An X/Z on a mon_* pin is treated as a mismatch, which is a simulation-only effect.

Optional Feature:
- Macro: DFF_CHK_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch moves CHECK -> HALT on that same edge.
  - In HALT all counters, the snapshot and the model freeze until reset; state reads 3.
- Undefined:
  - HALT is unreachable and checking continues after errors.
  - err_count keeps accumulating.

Test Plan:
- Reset and priming:
  - Stimulus: clear=0 for 3 cycles, then enable=1 with a correct flip-flop and mon_clear=mon_preset=1.
  - Required: state goes 0, then 1, then 2 after the second edge; sample_count=0 after the priming edges; all outputs are 0 during reset.
- Clean toggle run:
  - Stimulus: d toggling every 2 clocks with a correct flip-flop for 20 checked samples.
  - Required: sample_count=20, err_count=0, err_flag=0.
- Injected fault:
  - Stimulus: at checked sample 5, force mon_q=0 while exp=1.
  - Required: err_flag=1, err_count=1, first_err_ts=5, first_err_info=3'b101.
- Clear/preset sweep:
  - Stimulus: cycle {mon_clear,mon_preset} through 11, 00, 01, 10 every 4 clocks.
  - Required: illegal_count increments only during the 00 phase; a correct flip-flop gives err_count=0.
- Saturation:
  - Stimulus: CNT_W=4 with a stuck q for 40 checked samples.
  - Required: err_count=15, sample_count=15; first_err_ts unchanged from the first error.
- Stop-on-error:
  - Stimulus: DFF_CHK_STOP_ON_ERR_EN defined with the same injected fault at sample 5.
  - Required: state=3, err_count stays at 1 and sample_count stays at 5 afterwards; clear returns state to 0.
